// File: rtl/song_scroll_sched.sv
// Note-scroll scheduler for the LED matrix. It arms the selected song and generates the
// scroll step tick, pixel offset and note index, then sequences end-of-song and abort.
module song_scroll_sched #(
    parameter int TICK_DIV       = 100000,
    parameter int STEPS_PER_NOTE = 7,
    parameter int SONG_CNT       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_btn,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [9:0] song_len,
    output logic [1:0] song,
    output logic [1:0] sel_disp,
    output logic       step_tick,
    output logic [3:0] offset,
    output logic [9:0] note_idx,
    output logic       playing,
    output logic       paused,
    output logic       done
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       OFS_LAST = 4'(STEPS_PER_NOTE - 1);
    localparam logic [1:0]       SEL_LAST = 2'(SONG_CNT);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [1:0]       sel_q,    sel_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [3:0]       offset_q, offset_d;
    logic [9:0]       note_q,   note_d;
    logic [9:0]       len_q,    len_d;

    logic tick;
    logic last_step;

    // The last step of the last note ends the song; counters keep their final values.
    always_comb begin
        tick      = (state_q == ST_RUN) && (div_q == DIV_LAST);
        last_step = tick && (offset_q == OFS_LAST) && (note_q == len_q - 10'd1);
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        div_d    = div_q;
        offset_d = offset_q;
        note_d   = note_q;
        len_d    = len_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_btn) begin
                    sel_d = (sel_q == SEL_LAST) ? 2'd1 : sel_q + 2'd1;
                end
                if (start_btn) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                len_d    = song_len;
                div_d    = '0;
                offset_d = '0;
                note_d   = '0;
                state_d  = (song_len == 10'd0) ? ST_DONE : ST_RUN;
            end

            ST_RUN: begin
                if (start_btn) begin
                    state_d  = ST_IDLE;
                    div_d    = '0;
                    offset_d = '0;
                    note_d   = '0;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end else begin
                    // A step landing on the pause press is applied before freezing.
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        if (offset_q == OFS_LAST) begin
                            offset_d = '0;
                            note_d   = note_q + 10'd1;
                        end else begin
                            offset_d = offset_q + 4'd1;
                        end
                    end
                    if (pause_btn) begin
                        state_d = ST_PAUSE;
                    end
                end
            end

            ST_PAUSE: begin
                if (start_btn) begin
                    state_d  = ST_IDLE;
                    div_d    = '0;
                    offset_d = '0;
                    note_d   = '0;
                end else if (pause_btn) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                state_d  = ST_IDLE;
                div_d    = '0;
                offset_d = '0;
                note_d   = '0;
            end

            default: begin
                state_d  = ST_IDLE;
                div_d    = '0;
                offset_d = '0;
                note_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd1;
            div_q    <= '0;
            offset_q <= '0;
            note_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            div_q    <= div_d;
            offset_q <= offset_d;
            note_q   <= note_d;
            len_q    <= len_d;
        end
    end

    always_comb begin
        song      = ((state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_PAUSE)) ? sel_q : 2'd0;
        sel_disp  = sel_q;
        step_tick = tick;
        offset    = offset_q;
        note_idx  = note_q;
        playing   = (state_q == ST_RUN);
        paused    = (state_q == ST_PAUSE);
        done      = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_song_scroll_sched.sv
// Bench for song_scroll_sched: a run-cycle based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_song_scroll_sched;

    localparam int TD  = 4;
    localparam int SPN = 7;
    localparam int SC  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel_btn = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic [9:0] song_len = 10'd0;
    logic [1:0] song;
    logic [1:0] sel_disp;
    logic       step_tick;
    logic [3:0] offset;
    logic [9:0] note_idx;
    logic       playing;
    logic       paused;
    logic       done;

    always #5 clk = ~clk;

    song_scroll_sched #(
        .TICK_DIV       (TD),
        .STEPS_PER_NOTE (SPN),
        .SONG_CNT       (SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_btn   (sel_btn),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .song_len  (song_len),
        .song      (song),
        .sel_disp  (sel_disp),
        .step_tick (step_tick),
        .offset    (offset),
        .note_idx  (note_idx),
        .playing   (playing),
        .paused    (paused),
        .done      (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: progress is the number of RUN cycles played so far.
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
    int m_st, m_sel, m_rc, m_len;
    bit m_valid = 1'b0;
    int steps;

    always @(posedge clk) begin
        if (!rst) begin
            m_st = M_IDLE; m_sel = 1; m_rc = 0; m_len = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_st)
                M_IDLE: begin
                    if (sel_btn) m_sel = (m_sel == SC) ? 1 : m_sel + 1;
                    if (start_btn) m_st = M_ARM;
                end
                M_ARM: begin
                    m_len = int'(song_len);
                    m_rc  = 0;
                    m_st  = (song_len == 10'd0) ? M_DONE : M_RUN;
                end
                M_RUN: begin
                    if (start_btn) begin
                        m_st = M_IDLE; m_rc = 0;
                    end else if (m_rc + 1 == m_len * SPN * TD) begin
                        m_st = M_DONE;
                    end else begin
                        m_rc++;
                        if (pause_btn) m_st = M_PAUSE;
                    end
                end
                M_PAUSE: begin
                    if (start_btn) begin
                        m_st = M_IDLE; m_rc = 0;
                    end else if (pause_btn) begin
                        m_st = M_RUN;
                    end
                end
                default: begin
                    m_st = M_IDLE; m_rc = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            steps = m_rc / TD;
            check("song", int'(song),
                  (m_st == M_ARM || m_st == M_RUN || m_st == M_PAUSE) ? m_sel : 0);
            check("sel_disp", int'(sel_disp), m_sel);
            check("step_tick", int'(step_tick), (m_st == M_RUN && (m_rc % TD) == TD - 1) ? 1 : 0);
            check("offset", int'(offset), steps % SPN);
            check("note_idx", int'(note_idx), steps / SPN);
            check("playing", int'(playing), (m_st == M_RUN) ? 1 : 0);
            check("paused", int'(paused), (m_st == M_PAUSE) ? 1 : 0);
            check("done", int'(done), (m_st == M_DONE) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
    endtask

    int run_cyc, ticks, after7, held_ofs;
    bit done_seen;

    initial begin
        song_len = 10'd2;
        repeat (3) cyc();
        rst = 1'b1;
        check("rst_sel_disp", int'(sel_disp), 1);
        check("rst_song", int'(song), 0);
        check("rst_playing", int'(playing), 0);

        // Selection wraps 1 -> 2 -> 3 -> 1, then select+start arms the new value.
        sel_btn = 1'b1; cyc(); sel_btn = 1'b0; check("sel_a", int'(sel_disp), 2);
        sel_btn = 1'b1; cyc(); sel_btn = 1'b0; check("sel_b", int'(sel_disp), 3);
        sel_btn = 1'b1; cyc(); sel_btn = 1'b0; check("sel_c", int'(sel_disp), 1);
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0; check("idle_pause_ignored", int'(paused), 0);
        sel_btn = 1'b1; start_btn = 1'b1; cyc(); sel_btn = 1'b0; start_btn = 1'b0;
        check("arm_song", int'(song), 2);

        // Full song, two notes: 14 ticks over 56 RUN cycles, then done.
        cyc();
        run_cyc = 0; ticks = 0; after7 = 0; done_seen = 1'b0;
        for (int i = 0; i < 200 && !done_seen; i++) begin
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (after7 == 1) begin
                    check("note_after_tick7", int'(note_idx), 1);
                    check("ofs_after_tick7", int'(offset), 0);
                    after7 = 2;
                end
                if (step_tick) begin
                    ticks++;
                    if (ticks == 7) after7 = 1;
                end
                run_cyc++;
                cyc();
            end
        end
        check("full_done_seen", int'(done_seen), 1);
        check("full_run_cycles", run_cyc, 56);
        check("full_ticks", ticks, 14);
        check("full_final_ofs", int'(offset), 6);
        check("full_final_note", int'(note_idx), 1);
        cyc();
        check("full_done_once", int'(done), 0);
        check("full_idle_note", int'(note_idx), 0);

        // Pause with the divider frozen at 2; resume ticks two cycles later.
        song_len = 10'd3;
        pulse_start();
        cyc();
        cyc();
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        check("pause_entered", int'(paused), 1);
        held_ofs = int'(offset);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("pause_no_tick", int'(step_tick), 0);
            check("pause_ofs_held", int'(offset), held_ofs);
        end
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        check("resume_tick_c1", int'(step_tick), 0);
        cyc();
        check("resume_tick_c2", int'(step_tick), 1);
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        check("pause_again", int'(paused), 1);
        pulse_start();
        check("abort_done", int'(done), 0);
        check("abort_song", int'(song), 0);
        check("abort_paused", int'(paused), 0);
        cyc();
        check("abort_no_done_later", int'(done), 0);

        // Pause on the final tick loses to the end condition.
        song_len = 10'd1;
        pulse_start();
        cyc();
        repeat (27) cyc();
        check("coll_final_tick", int'(step_tick), 1);
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        check("coll_done", int'(done), 1);
        check("coll_not_paused", int'(paused), 0);
        cyc();
        check("coll_idle", int'(playing), 0);

        // Zero-length song goes ARM -> DONE -> IDLE.
        song_len = 10'd0;
        pulse_start();
        check("zero_arm_song", int'(song), 2);
        cyc();
        check("zero_done", int'(done), 1);
        check("zero_no_tick", int'(step_tick), 0);
        cyc();
        check("zero_idle", int'(done), 0);

        // Reset mid-run discards progress; sel_btn is ignored while playing.
        song_len = 10'd5;
        pulse_start();
        repeat (10) cyc();
        sel_btn = 1'b1; cyc(); sel_btn = 1'b0;
        check("run_sel_ignored", int'(sel_disp), 2);
        check("run_playing", int'(playing), 1);
        rst = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        check("mid_rst_sel", int'(sel_disp), 1);
        check("mid_rst_song", int'(song), 0);
        check("mid_rst_ofs", int'(offset), 0);
        check("mid_rst_note", int'(note_idx), 0);
        check("mid_rst_playing", int'(playing), 0);
        check("mid_rst_done", int'(done), 0);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/song_scroll_sched.md
Name: song_scroll_sched

Overview:
- Top-level scheduler for the note-scroll datapath on the LED matrix.
- Takes the player's song selection, start and pause buttons, and arms the selected song.
- Generates the scroll step tick, the pixel offset (0..STEPS_PER_NOTE-1) and the note index that drive the note loader and matrix refresh.
- Sequences end-of-song and abort, then returns to idle.

Parameters:
- TICK_DIV, 100000: clk cycles per scroll step (must be ≥2).
- STEPS_PER_NOTE, 7: pixel offsets per note index.
- SONG_CNT, 3: number of selectable songs (ids 1..SONG_CNT).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- sel_btn  in  1  debounced single-cycle pulse; cycles the song selection.
- start_btn  in  1  debounced single-cycle pulse; start in IDLE, abort in RUN/PAUSE.
- pause_btn  in  1  debounced single-cycle pulse; toggles RUN/PAUSE.
- song_len  in  10  note-index count of the song currently presented on `song`; sampled in ARM.
- song  out  2  song id to the loader: sel_reg in ARM/RUN/PAUSE, 0 otherwise.
- sel_disp  out  2  currently selected song id, for the selection display.
- step_tick  out  1  one-cycle pulse per scroll step.
- offset  out  4  pixel offset, 0..STEPS_PER_NOTE-1.
- note_idx  out  10  current note index.
- playing  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  one-cycle pulse when a song completes normally (not on abort).

Behaviour:
Reset:
- Reset is synchronous: when rst==0 at a clk edge, state=IDLE, sel_reg=1, div_cnt=0, offset=0, note_idx=0, len_reg=0, and all outputs are 0 except sel_disp=1.
- Reset mid-song discards all progress; there is no resume.

States:
- IDLE:
  - sel_btn advances sel_reg 1→2→…→SONG_CNT→1.
  - start_btn moves to ARM.
  - If sel_btn and start_btn arrive in the same cycle, the selection increments and ARM uses the new value.
- ARM (exactly 1 cycle):
  - song=sel_reg; latch len_reg=song_len; clear div_cnt, offset and note_idx.
  - Next state is RUN, or DONE if song_len==0.
- RUN:
  - div_cnt counts 0..TICK_DIV-1 and wraps.
  - step_tick=1 in the cycle div_cnt==TICK_DIV-1.
  - On a step_tick cycle:
    - If offset==STEPS_PER_NOTE-1: offset←0 and note_idx←note_idx+1.
    - Otherwise: offset←offset+1.
  - End condition: step_tick && offset==STEPS_PER_NOTE-1 && note_idx==len_reg-1 → DONE. Counters stay at their final values; no wrap is shown.
- PAUSE:
  - div_cnt, offset and note_idx are frozen; step_tick=0.
  - pause_btn resumes RUN at the same div_cnt, so no partial step is lost.
- DONE (1 cycle):
  - done=1 and song=0; next state is IDLE.
  - offset and note_idx are cleared on entry to IDLE.

Priority in RUN (highest first):
1. start_btn (abort → IDLE, no done pulse).
2. End condition (→ DONE).
3. pause_btn (→ PAUSE).

Priority in PAUSE: start_btn (abort) over pause_btn.

Other rules:
- A step_tick coinciding with pause_btn is still applied before PAUSE is entered.
- sel_btn is ignored outside IDLE.
- pause_btn is ignored in IDLE, ARM and DONE.
- Widths: div_cnt is clog2(TICK_DIV) bits. note_idx arithmetic is 10-bit; since len_reg≤1023, note_idx never overflows.

Latency:
- start_btn to song!=0: 1 cycle.
- First step_tick: TICK_DIV cycles after entering RUN.
- Total song: len_reg × STEPS_PER_NOTE × TICK_DIV RUN cycles, excluding paused time.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-RUN → next cycle state IDLE, sel_disp=1, song=0, offset=0, note_idx=0, playing=0, done=0.
- Selection wrap: in IDLE pulse sel_btn 3 times → sel_disp 2, 3, 1. Then sel_btn+start_btn in the same cycle → ARM with song=2.
- Full song: TICK_DIV=4, STEPS=7, song_len=2, start → step_tick every 4 cycles; note_idx becomes 1 at tick 7; done pulses once, the cycle after tick 14 (56 RUN cycles); final offset=6, note_idx=1 during DONE.
- Pause: TICK_DIV=4; pause at div_cnt=2, wait 20 cycles, resume → next step_tick exactly 2 cycles after resume; offset is unchanged during pause.
- Abort and collision: start_btn in PAUSE → IDLE with no done. In RUN, assert pause_btn on the final end-condition tick → DONE (not PAUSE), done=1.
- Zero length: song_len=0, start → ARM→DONE→IDLE, done=1, step_tick never asserts.
